// File: rtl/accel_readback_pkg.sv
// Shared sizes, FSM encoding, output beat layout and the compact-to-full index map.
package accel_readback_pkg;

    localparam int unsigned ARRAY_SIZE = 50;
    localparam int unsigned WORD_WIDTH = 4;
    localparam int unsigned SHIL       = ARRAY_SIZE / 2;
    localparam int unsigned ACC_SIZE   = ARRAY_SIZE - 4;
    localparam int unsigned ADDR_W     = $clog2(ARRAY_SIZE);
    localparam int unsigned ROW_W      = ARRAY_SIZE * WORD_WIDTH;
    localparam int unsigned ACC_ROW_W  = ACC_SIZE * WORD_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] row_address;
        logic [ROW_W-1:0]  row_weights;
    } out_beat_t;

    // Compact index to full index: skip full position 0 and the two middle positions.
    function automatic int unsigned full_index(input int unsigned i);
        return (i < SHIL - 1) ? i + 1 : i + 3;
    endfunction

endpackage

// File: rtl/accel_readback_if.sv
// Compact-memory read port plus the expanded-row valid/ready stream.
interface accel_readback_if;
    import accel_readback_pkg::*;

    logic                 acc_rd_en;
    logic [ADDR_W-1:0]    acc_rd_addr;
    logic [ACC_ROW_W-1:0] acc_rd_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_W-1:0]    out_row_address;
    logic [ROW_W-1:0]     out_row_weights;

    modport master (
        output acc_rd_en, acc_rd_addr, out_valid, out_row_address, out_row_weights,
        input  acc_rd_data, out_ready
    );

    modport slave (
        input  acc_rd_en, acc_rd_addr, out_valid, out_row_address, out_row_weights,
        output acc_rd_data, out_ready
    );

endinterface

// File: rtl/accel_row_expand.sv
// Expands a compact vector of W-bit elements to full width and maps a compact row index.
module accel_row_expand
    import accel_readback_pkg::*;
#(
    parameter int unsigned     W   = WORD_WIDTH,
    // Fill elements for full positions {ARRAY_SIZE-1, SHIL+1, SHIL, 0}
    parameter logic [4*W-1:0]  PAD = '0
) (
    input  logic [ACC_SIZE*W-1:0]   compact,
    input  logic [ADDR_W-1:0]       acc_row,
    output logic [ARRAY_SIZE*W-1:0] full_c,
    output logic [ADDR_W-1:0]       full_row_c
);

    // Route each compact element to its full position
    for (genvar j = 0; j < int'(ACC_SIZE); j++) begin : g_map
        localparam int unsigned F = full_index(j);
        assign full_c[F*W +: W] = compact[j*W +: W];
    end

    // Positions with no compact counterpart take the pad elements
    assign full_c[0 +: W]                  = PAD[0 +: W];
    assign full_c[SHIL*W +: W]             = PAD[W +: W];
    assign full_c[(SHIL+1)*W +: W]         = PAD[2*W +: W];
    assign full_c[(ARRAY_SIZE-1)*W +: W]   = PAD[3*W +: W];

    assign full_row_c = ADDR_W'(full_index(32'(acc_row)));

endmodule

// File: rtl/accel_readback.sv
// Reads every compact accelerator row and streams it out expanded to full-array width.
module accel_readback
    import accel_readback_pkg::*;
#(
    parameter logic [3:0] SPIN_PAD = 4'b0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ACC_SIZE-1:0]   acc_spins,
    accel_readback_if.master      bus,
    output logic [ARRAY_SIZE-1:0] spins_full,
    output logic                  busy,
    output logic                  done
);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   cnt;
    logic                rd_en;
    logic                valid;
    out_beat_t           beat;

    logic                rd_en_next;
    logic                valid_next;
    logic                busy_next;
    logic                done_next;
    logic                last_row_c;

    logic [ROW_W-1:0]      weights_full_c;
    logic [ADDR_W-1:0]     row_full_c;
    logic [ARRAY_SIZE-1:0] spins_full_c;
    logic [ADDR_W-1:0]     spin_row_unused;

    assign last_row_c = (cnt == ADDR_W'(ACC_SIZE - 1));

    accel_row_expand #(
        .W   (WORD_WIDTH),
        .PAD ('0)
    ) u_weight_expand (
        .compact    (bus.acc_rd_data),
        .acc_row    (cnt),
        .full_c     (weights_full_c),
        .full_row_c (row_full_c)
    );

    accel_row_expand #(
        .W   (1),
        .PAD (SPIN_PAD)
    ) u_spin_expand (
        .compact    (acc_spins),
        .acc_row    (cnt),
        .full_c     (spins_full_c),
        .full_row_c (spin_row_unused)
    );

    // State register and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            rd_en <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            rd_en <= rd_en_next;
            valid <= valid_next;
            busy  <= busy_next;
            done  <= done_next;
        end
    end

    // Next-state: one read per row, hold each row until the consumer takes it
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  state_next = ST_HOLD;
            ST_HOLD:  if (bus.out_ready) state_next = last_row_c ? ST_FIN : ST_ISSUE;
            ST_FIN:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the upcoming state so they align with it once registered
    always_comb begin
        rd_en_next = 1'b0;
        valid_next = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        case (state_next)
            ST_ISSUE: begin rd_en_next = 1'b1; busy_next = 1'b1; end
            ST_WAIT:  busy_next = 1'b1;
            ST_HOLD:  begin valid_next = 1'b1; busy_next = 1'b1; end
            ST_FIN:   begin done_next = 1'b1; busy_next = 1'b1; end
            default:  ;
        endcase
    end

    // Row counter, spin snapshot and output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            spins_full <= '0;
            beat       <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                spins_full <= spins_full_c;
                cnt        <= '0;
            end
            if (state == ST_WAIT) begin
                beat.row_address <= row_full_c;
                beat.row_weights <= weights_full_c;
            end
            if (state == ST_HOLD && bus.out_ready && !last_row_c) begin
                cnt <= cnt + ADDR_W'(1);
            end
        end
    end

    assign bus.acc_rd_en       = rd_en;
    assign bus.acc_rd_addr     = cnt;
    assign bus.out_valid       = valid;
    assign bus.out_row_address = beat.row_address;
    assign bus.out_row_weights = beat.row_weights;

endmodule

// File: tb/tb_accel_readback.sv
// Bench for accel_readback: memory model, ready driver, scoreboard monitor and vector table.
module tb_accel_readback;
    import accel_readback_pkg::*;

    localparam int NA   = ARRAY_SIZE;
    localparam int NACC = ACC_SIZE;
    localparam int NSH  = SHIL;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic [ACC_SIZE-1:0]   acc_spins;
    logic [ARRAY_SIZE-1:0] spins_full;
    logic                  busy;
    logic                  done;

    accel_readback_if bus ();

    accel_readback #(.SPIN_PAD(4'b1001)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .acc_spins  (acc_spins),
        .bus        (bus),
        .spins_full (spins_full),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  w;
    } exp_t;

    typedef struct {
        logic [ACC_SIZE-1:0]   spins;
        int                    mode;
        int                    ready_mode;
        bit                    extra;
        logic [ARRAY_SIZE-1:0] exp_spins;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[5];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int cur_mode = 0;
    int ready_mode = 0;
    int rows_seen = 0;
    int exp_rd = 0;
    int bp_cnt = 0;
    int first_valid_cyc = -1;
    int done_count = 0;
    int got_addr[64];
    bit hold_prev = 1'b0;
    bit done_prev = 1'b0;
    logic [ADDR_W-1:0] snap_addr;
    logic [ROW_W-1:0]  snap_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] word_of(input int r, input int j, input int m);
        return (m == 0) ? 4'(r % 16) : 4'((r * 3 + j) % 16);
    endfunction

    function automatic logic [ACC_ROW_W-1:0] make_row(input int r, input int m);
        logic [ACC_ROW_W-1:0] v;
        v = '0;
        for (int j = 0; j < NACC; j++) v[j*4 +: 4] = word_of(r, j, m);
        return v;
    endfunction

    function automatic logic [ACC_ROW_W-1:0] garbage();
        logic [ACC_ROW_W-1:0] v;
        v = '0;
        for (int j = 0; j < NACC; j++) v[j*4 +: 4] = 4'($urandom_range(0, 15));
        return v;
    endfunction

    // Expected full row derived from the full-side position back to its compact source
    function automatic logic [ROW_W-1:0] exp_weights(input int r, input int m);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int f = 0; f < NA; f++) begin
            if (f == 0 || f == NSH || f == NSH + 1 || f == NA - 1) v[f*4 +: 4] = 4'h0;
            else v[f*4 +: 4] = word_of(r, (f < NSH) ? f - 1 : f - 3, m);
        end
        return v;
    endfunction

    // Compact memory: data valid the cycle after the strobe, noise otherwise
    always @(posedge clk) begin
        if (bus.acc_rd_en) bus.acc_rd_data <= make_row(int'(bus.acc_rd_addr), cur_mode);
        else               bus.acc_rd_data <= garbage();
    end

    // Consumer ready: tied high, random, or a 10-cycle stall on row 5
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.out_valid && rows_seen == 5 && bp_cnt < 10) begin
                        bus.out_ready = 1'b0;
                        bp_cnt++;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: read sequence, scoreboard push/pop, hold stability, done pulse width
    initial begin
        forever begin
            @(negedge clk);
            if (hold_prev) begin
                check("hold_valid", 256'(bus.out_valid), 256'(1));
                check("hold_addr", 256'(bus.out_row_address), 256'(snap_addr));
                check("hold_weights", 256'(bus.out_row_weights), 256'(snap_w));
            end
            if (bus.out_valid) check("no_read_while_valid", 256'(bus.acc_rd_en), 256'(0));
            if (bus.acc_rd_en) begin
                check("rd_addr", 256'(bus.acc_rd_addr), 256'(exp_rd));
                e.addr = 6'((int'(bus.acc_rd_addr) < NSH - 1) ? int'(bus.acc_rd_addr) + 1
                                                              : int'(bus.acc_rd_addr) + 3);
                e.w = exp_weights(int'(bus.acc_rd_addr), cur_mode);
                sb.push_back(e);
                exp_rd++;
            end
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", 256'(sb.size() != 0), 256'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("row_addr", 256'(bus.out_row_address), 256'(e.addr));
                    check("row_weights", 256'(bus.out_row_weights), 256'(e.w));
                end
                if (rows_seen < 64) got_addr[rows_seen] = int'(bus.out_row_address);
                rows_seen++;
            end
            if (done) begin
                check("done_one_cycle", 256'(done_prev), 256'(0));
                done_count++;
            end
            done_prev = done;
            hold_prev = bus.out_valid && !bus.out_ready;
            snap_addr = bus.out_row_address;
            snap_w    = bus.out_row_weights;
        end
    end

    task automatic run(input vec_t v, input int idx);
        int start_cyc;
        int done_cyc;
        bit got;
        cur_mode        = v.mode;
        ready_mode      = v.ready_mode;
        rows_seen       = 0;
        exp_rd          = 0;
        bp_cnt          = 0;
        first_valid_cyc = -1;
        @(negedge clk);
        start     = 1'b1;
        acc_spins = v.spins;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
            end else if (v.extra && (i == 20 || i == 61)) begin
                start     = 1'b1;
                acc_spins = ~v.spins;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", 256'(got), 256'(1));
        check("spins_full", 256'(spins_full), 256'(v.exp_spins));
        check("row_count", 256'(rows_seen), 256'(NACC));
        check("sb_drained", 256'(sb.size()), 256'(0));
        check("first_valid_latency", 256'(first_valid_cyc - start_cyc), 256'(3));
        // Start cycle through done cycle inclusive
        if (v.ready_mode == 0) check("run_cycles", 256'(done_cyc - start_cyc + 1), 256'(3 * NACC + 2));
        if (v.ready_mode == 2) check("stall_cycles", 256'(bp_cnt), 256'(10));
        if (idx == 0) begin
            check("boundary_row0", 256'(got_addr[0]), 256'(1));
            check("boundary_row23", 256'(got_addr[23]), 256'(24));
            check("boundary_row24", 256'(got_addr[24]), 256'(27));
            check("boundary_row45", 256'(got_addr[45]), 256'(48));
        end
        @(negedge clk);
        check("idle_after_run", 256'(busy), 256'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dcount;
        vecs[0] = '{46'h3FFFFFFFFFFF, 0, 0, 1'b0, 50'h3FFFFF9FFFFFF};
        vecs[1] = '{46'h000000000001, 1, 1, 1'b0, 50'h2000000000003};
        vecs[2] = '{46'h000001800000, 1, 2, 1'b0, 50'h2000009000001};
        vecs[3] = '{46'h200000000000, 0, 0, 1'b1, 50'h3000000000001};
        vecs[4] = '{46'h000000000000, 1, 0, 1'b0, 50'h2000000000001};

        rst_n     = 1'b0;
        start     = 1'b0;
        acc_spins = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_valid", 256'(bus.out_valid), 256'(0));
        check("rst_rd_en", 256'(bus.acc_rd_en), 256'(0));
        check("rst_rd_addr", 256'(bus.acc_rd_addr), 256'(0));
        check("rst_row_addr", 256'(bus.out_row_address), 256'(0));
        check("rst_weights", 256'(bus.out_row_weights), 256'(0));
        check("rst_spins_full", 256'(spins_full), 256'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", 256'(busy), 256'(0));
        check("post_rst_valid", 256'(bus.out_valid), 256'(0));
        check("post_rst_spins_full", 256'(spins_full), 256'(0));

        for (int k = 0; k < 5; k++) run(vecs[k], k);

        // Reset in the middle of a run aborts at once and never reports done
        cur_mode   = 0;
        ready_mode = 1;
        exp_rd     = 0;
        rows_seen  = 0;
        @(negedge clk);
        start     = 1'b1;
        acc_spins = 46'h15555555555;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst_n = 1'b0;
        hold_prev = 1'b0;
        #1;
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_valid", 256'(bus.out_valid), 256'(0));
        check("abort_rd_en", 256'(bus.acc_rd_en), 256'(0));
        check("abort_done", 256'(done), 256'(0));
        check("abort_spins_full", 256'(spins_full), 256'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        dcount = done_count;
        repeat (200) @(negedge clk);
        check("abort_no_done", 256'(done_count), 256'(dcount));
        check("abort_stays_idle", 256'(busy), 256'(0));

        run(vecs[4], 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/accel_readback.md
Name: accel_readback

Overview:
- Read-back path from the compact accelerator format to the full logical ARRAY_SIZE format.
- On start, samples the compact accelerator spin vector and expands it to ARRAY_SIZE bits with fixed pads.
- Walks every compact accelerator row (0..ARRAY_SIZE-5) through a 1-cycle-latency memory read port.
- Emits each row, expanded to full width and tagged with its full-array row index, over a valid/ready stream.

Parameters:
- ARRAY_SIZE, 50, full logical array dimension; the accelerator holds ARRAY_SIZE-4 rows/columns.
- WORD_WIDTH, 4, bits per weight word.
- SHIL, 25, index of the first of the two dropped middle positions; SHIL == ARRAY_SIZE/2 is required.
- SPIN_PAD, 4'b0000, fill bits for dropped spins in order {ARRAY_SIZE-1, SHIL+1, SHIL, 0}.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- acc_spins  in  ARRAY_SIZE-4  compact spin vector.
- acc_rd_en  out  1  read strobe to compact memory.
- acc_rd_addr  out  $clog2(ARRAY_SIZE)  compact row index.
- acc_rd_data  in  (ARRAY_SIZE-4)*WORD_WIDTH  read data, valid the cycle after acc_rd_en.
- out_valid  out  1  expanded row available.
- out_ready  in  1  consumer accepts.
- out_row_address  out  $clog2(ARRAY_SIZE)  full-array row index.
- out_row_weights  out  ARRAY_SIZE*WORD_WIDTH  expanded row.
- spins_full  out  ARRAY_SIZE  expanded spin vector.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset: every output and internal register is 0 and the FSM is in IDLE; spins_full is 0, not SPIN_PAD. Assertion mid-run aborts immediately; no done pulse.
- FSM states: IDLE, ISSUE, WAIT, HOLD, FIN.
- IDLE: on start, latch the expanded acc_spins into spins_full, clear the row counter cnt, go to ISSUE. start is ignored in all other states.
- ISSUE: acc_rd_en=1 for exactly one cycle, acc_rd_addr=cnt, go to WAIT.
- WAIT: acc_rd_data is valid this cycle. Register the expanded row and its address, go to HOLD.
- HOLD: out_valid=1 and outputs stay stable until out_ready.
  - On handshake with cnt==ARRAY_SIZE-5: go to FIN.
  - On handshake otherwise: cnt+1, go to ISSUE.
  - out_valid drops the cycle after the handshake.
- FIN: done=1 for one cycle, go to IDLE. spins_full holds until the next accepted start.
- Timing: first out_valid 3 cycles after start. With out_ready tied high, one row is accepted every 3 cycles and a full run is 3*(ARRAY_SIZE-4)+2 cycles from start to done.
- Address map, compact row r to full row: r<SHIL-1 gives r+1; otherwise r+3. Full rows 0, SHIL, SHIL+1 and ARRAY_SIZE-1 are never produced.
- Weight expansion, compact word j goes to full word j+1 (j<SHIL-1) or j+3 (j>=SHIL-1). Full words 0, SHIL, SHIL+1 and ARRAY_SIZE-1 are zero.
- Spin expansion uses the same index map; dropped positions take SPIN_PAD bits.
- out_ready may be high while out_valid is low; this has no effect.
- acc_rd_data is sampled only in WAIT.

Decomposition:
- Shared package holds ARRAY_SIZE, WORD_WIDTH, SHIL, the derived ACC_SIZE=ARRAY_SIZE-4, and the FSM state enum.
- One combinational sub-module, accel_row_expand, performs the word/spin index expansion and the address map. It is reused for both weights and spins via a width parameter.
- The top level holds the FSM, counter and output registers.

Test Plan:
- Reset values: reset held, then released -> all outputs 0 and busy=0; a start mid-run followed by reset -> busy=0 and out_valid=0 immediately, and no done pulse follows.
- Full run: compact row r data = each word set to (r mod 16), out_ready=1 -> 46 rows with addresses 1..24 then 27..48; words 0, 25, 26, 49 zero and all others = r mod 16; done exactly 140 cycles after start.
- Backpressure: out_ready low for 10 cycles on row 5 -> out_valid stays high and data stays stable; no further acc_rd_en until the handshake; the next read is addr 6.
- Spin expansion: acc_spins=46'h3FFF_FFFF_FFFF with SPIN_PAD=4'b1001 -> spins_full bits 0 and 49 =1, bits 25 and 26 =0, rest 1. acc_spins=1 -> spins_full bit 1 set, with bits 0 and 49 =1 from SPIN_PAD.
- Boundary row: compact row 23 -> out_row_address 24; compact row 24 -> 27; compact row 45 -> 48.
- Ignored start: start pulses while busy -> no restart, spins_full unchanged, and the row sequence continues uninterrupted.
